// File: rtl/hilo_reg_8.sv
// hilo_reg_8: HI/LO product register pair with LAT-cycle multiply commit, move-to/move-from access and interlock
//   clk                  rising-edge clock
//   reset                asynchronous active-low reset
//   FS, mul_valid        multiply issue request (accepted when FS == 5'h2 and mul_ready)
//   VY_hi, VY_lo         product bytes captured at accept
//   mul_ready            high while IDLE
//   mt_hi, mt_lo, D_in   move-to-HI/LO writes, honoured only while IDLE
//   rd_hi, rd_lo         move-from-HI/LO reads; rd_data is combinational, rd_hi has priority
//   stall                any HI/LO access while a product is pending
//   HI, LO, N, Z         architectural registers and flags of {HI,LO}
module hilo_reg_8 #(
  parameter int LAT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] FS,
  input  logic [7:0] VY_hi,
  input  logic [7:0] VY_lo,
  input  logic       mul_valid,
  output logic       mul_ready,
  input  logic       mt_hi,
  input  logic       mt_lo,
  input  logic [7:0] D_in,
  input  logic       rd_hi,
  input  logic       rd_lo,
  output logic [7:0] rd_data,
  output logic       stall,
  output logic [7:0] HI,
  output logic [7:0] LO,
  output logic       N,
  output logic       Z
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [1:0] CNT_INIT = 2'(LAT - 1);
  state_t      r_state;
  logic [1:0]  r_cnt;
  logic [15:0] r_p;
  logic [7:0]  r_hi, r_lo;
  logic        r_n, r_z;
  logic        w_busy, w_accept;
  logic [7:0]  w_hi_nx, w_lo_nx;
  assign w_busy    = r_state == BUSY;
  assign w_accept  = mul_valid && FS == 5'h2 && !w_busy;
  // values HI/LO take after an IDLE move-to write, used for both the registers and the flags
  assign w_hi_nx   = mt_hi ? D_in : r_hi;
  assign w_lo_nx   = mt_lo ? D_in : r_lo;
  assign mul_ready = !w_busy;
  assign stall     = (rd_hi | rd_lo | mt_hi | mt_lo) && w_busy;
  assign rd_data   = rd_hi ? r_hi : rd_lo ? r_lo : 8'h00;
  assign HI        = r_hi;
  assign LO        = r_lo;
  assign N         = r_n;
  assign Z         = r_z;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= 2'd0;
      r_p     <= 16'h0;
      r_hi    <= 8'h00;
      r_lo    <= 8'h00;
      r_n     <= 1'b0;
      r_z     <= 1'b1;
    end else if (w_busy) begin
      if (r_cnt != 2'd0) r_cnt <= r_cnt - 2'd1;
      else begin
        r_hi    <= r_p[15:8];
        r_lo    <= r_p[7:0];
        r_n     <= r_p[15];
        r_z     <= r_p == 16'h0;
        r_state <= IDLE;
      end
    end else begin
      // a move-to write and an accept may share this edge; the later commit overwrites both halves
      if (mt_hi || mt_lo) begin
        r_hi <= w_hi_nx;
        r_lo <= w_lo_nx;
        r_n  <= w_hi_nx[7];
        r_z  <= {w_hi_nx, w_lo_nx} == 16'h0;
      end
      if (w_accept) begin
        r_p     <= {VY_hi, VY_lo};
        r_cnt   <= CNT_INIT;
        r_state <= BUSY;
      end
    end
  end
endmodule
